// File: rtl/ne_window_sum_pkg.sv
// Shared defaults, sum-width helper and FSM state type for the NE window sum.
package ne_pkg;

    localparam int NE_IN_W    = 64;
    localparam int NE_WIN_LEN = 16;

    // Sum width that cannot overflow for WIN_LEN samples of in_w bits.
    function automatic int ne_sum_w(input int in_w, input int win_len);
        return in_w + $clog2(win_len);
    endfunction

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } ne_state_e;

endpackage

// File: rtl/ne_window_sum_ram.sv
// WIN_LEN x IN_W sample store: one write port, one combinational read port.
// No reset; stale entries are masked by the fill logic in the top level.
module ne_win_ram #(
    parameter int IN_W    = 64,
    parameter int WIN_LEN = 16,
    localparam int AW     = $clog2(WIN_LEN)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [IN_W-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [IN_W-1:0] rdata
);

    logic [IN_W-1:0] mem_q [WIN_LEN];

    // Write the incoming sample; reads of the same entry this cycle see old data.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ne_window_sum.sv
// Sliding-window sum of the last WIN_LEN signed NE samples.
// Optional threshold detector enabled by defining NE_SUM_DETECT_EN.
module ne_window_sum
    import ne_pkg::*;
#(
    parameter int IN_W    = NE_IN_W,
    parameter int WIN_LEN = NE_WIN_LEN,
    localparam int SUM_W  = ne_sum_w(IN_W, WIN_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  din,
    input  logic             din_valid,
    input  logic             clear,
    output logic [SUM_W-1:0] sum,
    output logic             sum_valid,
    output logic             full
`ifdef NE_SUM_DETECT_EN
    ,
    input  logic [SUM_W-1:0] thresh,
    output logic             detect
`endif
);

    localparam int PTR_W = $clog2(WIN_LEN);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIN_LEN);

    ne_state_e        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic             full_q, full_d;
    logic [IN_W-1:0]  rd_data;
    logic [SUM_W-1:0] din_ext, old_ext;
    logic             wr_en;

    // A cleared cycle drops its sample, so it must not touch the buffer.
    assign wr_en = din_valid && !clear;

    ne_win_ram #(
        .IN_W    (IN_W),
        .WIN_LEN (WIN_LEN)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (wr_ptr_q),
        .rdata (rd_data)
    );

    assign din_ext = {{(SUM_W-IN_W){din[IN_W-1]}}, din};
    // During fill the slot being overwritten holds stale data; treat it as zero.
    assign old_ext = (state_q == ST_RUN) ? {{(SUM_W-IN_W){rd_data[IN_W-1]}}, rd_data}
                                         : '0;

    // Next-state, pointer, fill counter and accumulator update.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        full_d      = full_q;
        if (clear) begin
            state_d    = ST_FILL;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
            sum_d      = '0;
            full_d     = 1'b0;
        end else if (din_valid) begin
            sum_d    = sum_q + din_ext - old_ext;
            wr_ptr_d = wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
            if (state_q == ST_FILL) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_d == CNT_FULL) state_d = ST_RUN;
            end
            sum_valid_d = (fill_cnt_d == CNT_FULL);
            full_d      = (fill_cnt_d == CNT_FULL);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            full_q      <= full_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign full      = full_q;

`ifdef NE_SUM_DETECT_EN
    logic detect_q, detect_d;

    // Re-evaluate the threshold only when a full-window sum is produced.
    always_comb begin
        detect_d = detect_q;
        if (clear)            detect_d = 1'b0;
        else if (sum_valid_d) detect_d = ($signed(sum_d) > $signed(thresh));
    end

    // Detect flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) detect_q <= 1'b0;
        else        detect_q <= detect_d;
    end

    assign detect = detect_q;
`endif

endmodule
